rvfi_commit_serializer: RTL and testbench

Serializes the NR_COMMIT_PORTS-wide RVFI commit bundle from the core into a single in-order stream of one rvfi_pkg::rvfi_instr_t per handshake, buffered in a FIFO. It sits between the core's RVFI output and any single-port trace or checker consumer. It sequences end-of-test drain so that no retired instruction is lost when simulation terminates. It cannot backpressure the core: on overflow it drops entries and records the drop.

---
 rtl/rvfi_pkg.sv | 20 ++
 rtl/rvfi_ser_pkg.sv | 16 +
 rtl/rvfi_commit_compactor.sv | 29 ++
 rtl/rvfi_commit_serializer.sv | 130 +++++++++++++
 tb/tb_rvfi_commit_serializer.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/rvfi_pkg.sv
// RVFI retirement record shared by the core, tracers and checkers.
// One entry describes a single retired instruction or trap.
package rvfi_pkg;

    typedef struct packed {
        logic        valid;
        logic [63:0] order;
        logic [31:0] insn;
        logic        trap;
        logic [31:0] cause;
        logic        halt;
        logic        intr;
        logic [1:0]  mode;
        logic [4:0]  rd_addr;
        logic [31:0] rd_wdata;
        logic [31:0] pc_rdata;
        logic [31:0] pc_wdata;
    } rvfi_instr_t;

endpackage

// File: rtl/rvfi_ser_pkg.sv
// Shared types and constants for the RVFI commit serializer.
package rvfi_ser_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } ser_state_e;

    localparam logic [31:0] DROP_CNT_MAX = 32'hFFFF_FFFF;

    function automatic int ptr_w(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/rvfi_commit_compactor.sv
// Packs the qualifying commit-port entries into the low slots, oldest port first,
// and reports how many there are. Purely combinational.
module rvfi_commit_compactor #(
    parameter int NR_COMMIT_PORTS = 2,
    parameter int N_W             = $clog2(NR_COMMIT_PORTS + 1)
) (
    input  logic [NR_COMMIT_PORTS-1:0]                 qual,
    input  rvfi_pkg::rvfi_instr_t [NR_COMMIT_PORTS-1:0] bundle,
    output rvfi_pkg::rvfi_instr_t [NR_COMMIT_PORTS-1:0] compact,
    output logic [N_W-1:0]                             n
);

    always_comb begin
        int slot;
        slot    = 0;
        compact = '0;
        // Constant-index inner loop keeps the slot select a plain mux tree.
        for (int i = 0; i < NR_COMMIT_PORTS; i++) begin
            if (qual[i]) begin
                for (int j = 0; j < NR_COMMIT_PORTS; j++) begin
                    if (j == slot) compact[j] = bundle[i];
                end
                slot++;
            end
        end
        n = N_W'(slot);
    end

endmodule

// File: rtl/rvfi_commit_serializer.sv
// Serializes the multi-port RVFI commit bundle into a single in-order FIFO stream
// with end-of-test drain. Optional macro RVFI_SERIALIZER_TRAP_FWD_EN forwards trap-only entries.
module rvfi_commit_serializer
    import rvfi_pkg::*;
    import rvfi_ser_pkg::*;
#(
    parameter int NR_COMMIT_PORTS = 2,
    parameter int DEPTH           = 16
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  rvfi_instr_t [NR_COMMIT_PORTS-1:0] rvfi_i,
    output rvfi_instr_t                      rvfi_o,
    output logic                             rvfi_valid_o,
    input  logic                             rvfi_ready_i,
    input  logic [31:0]                      end_of_test_i,
    output logic [$clog2(DEPTH):0]           level_o,
    output logic [$clog2(DEPTH):0]           max_level_o,
    output logic [31:0]                      drop_cnt_o,
    output logic                             overflow_o,
    output logic                             done_o
);

    localparam int PTR_W = ptr_w(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int N_W   = $clog2(NR_COMMIT_PORTS + 1);

    ser_state_e state, state_next;

    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count, count_next, max_level, n_ext;
    logic [CNT_W:0]   space_sum;
    logic [32:0]      drop_sum;
    logic [31:0]      drop_cnt;
    logic             overflow;
    logic             fits, accept, drop, pop;

    logic [NR_COMMIT_PORTS-1:0]        qual;
    rvfi_instr_t [NR_COMMIT_PORTS-1:0] compact;
    logic [N_W-1:0]                    n_in;

    rvfi_instr_t mem [DEPTH];

    always_comb begin
        for (int i = 0; i < NR_COMMIT_PORTS; i++) begin
`ifdef RVFI_SERIALIZER_TRAP_FWD_EN
            qual[i] = rvfi_i[i].valid | rvfi_i[i].trap;
`else
            qual[i] = rvfi_i[i].valid;
`endif
        end
    end

    rvfi_commit_compactor #(
        .NR_COMMIT_PORTS(NR_COMMIT_PORTS),
        .N_W            (N_W)
    ) u_compactor (
        .qual   (qual),
        .bundle (rvfi_i),
        .compact(compact),
        .n      (n_in)
    );

    // Space check uses only the registered count, so a same-cycle pop never frees room.
    assign n_ext      = CNT_W'(n_in);
    assign space_sum  = {1'b0, count} + {1'b0, n_ext};
    assign fits       = space_sum <= (CNT_W + 1)'(DEPTH);
    assign accept     = (state == RUN) && (n_in != '0) && fits;
    assign drop       = (state == RUN) && (n_in != '0) && !fits;
    assign pop        = rvfi_valid_o && rvfi_ready_i;
    assign count_next = count + (accept ? n_ext : '0) - {{(CNT_W-1){1'b0}}, pop};
    assign drop_sum   = {1'b0, drop_cnt} + 33'(n_in);

    always_ff @(posedge clk_i) begin
        if (accept) begin
            for (int j = 0; j < NR_COMMIT_PORTS; j++) begin
                if (N_W'(j) < n_in) mem[wr_ptr + PTR_W'(j)] <= compact[j];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            count     <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            max_level <= '0;
            drop_cnt  <= '0;
            overflow  <= 1'b0;
        end else begin
            count <= count_next;
            if (accept) wr_ptr <= wr_ptr + PTR_W'(n_in);
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (count_next > max_level) max_level <= count_next;
            if (drop) begin
                drop_cnt <= drop_sum[32] ? DROP_CNT_MAX : drop_sum[31:0];
                overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) state <= RUN;
        else         state <= state_next;
    end

    // DRAIN finishes once the FIFO is (or is about to be) empty, which covers both
    // an empty entry into DRAIN and the final pop.
    always_comb begin
        state_next = state;
        unique case (state)
            RUN:     if (end_of_test_i != 32'd0) state_next = DRAIN;
            DRAIN:   if (count_next == '0) state_next = DONE;
            DONE:    state_next = DONE;
            default: state_next = RUN;
        endcase
    end

    always_comb begin
        rvfi_valid_o = (state != DONE) && (count != '0);
        rvfi_o       = rvfi_valid_o ? mem[rd_ptr] : '0;
        done_o       = (state == DONE);
    end

    assign level_o     = count;
    assign max_level_o = max_level;
    assign drop_cnt_o  = drop_cnt;
    assign overflow_o  = overflow;

endmodule

// File: tb/tb_rvfi_commit_serializer.sv
// Randomized self-checking bench for rvfi_commit_serializer against a queue-based model.
module tb_rvfi_commit_serializer;
    import rvfi_pkg::*;

    localparam int NP    = 2;
    localparam int DEPTH = 16;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic                  clk = 1'b0;
    logic                  rst_n;
    rvfi_instr_t [NP-1:0]  rvfi_in;
    rvfi_instr_t           rvfi_out;
    logic                  vld;
    logic                  rdy;
    logic [31:0]           eot;
    logic [CW-1:0]         level;
    logic [CW-1:0]         max_level;
    logic [31:0]           drop_cnt;
    logic                  ovf;
    logic                  done;

    always #5 clk = ~clk;

    rvfi_commit_serializer #(
        .NR_COMMIT_PORTS(NP),
        .DEPTH          (DEPTH)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .rvfi_i       (rvfi_in),
        .rvfi_o       (rvfi_out),
        .rvfi_valid_o (vld),
        .rvfi_ready_i (rdy),
        .end_of_test_i(eot),
        .level_o      (level),
        .max_level_o  (max_level),
        .drop_cnt_o   (drop_cnt),
        .overflow_o   (ovf),
        .done_o       (done)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: FIFO contents as a queue plus the observable counters.
    rvfi_instr_t q[$];
    logic [31:0] m_drop;
    bit          m_ovf;
    int          m_max;
    bit          m_drain;
    bit          m_done;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit qualifies(input rvfi_instr_t e);
`ifdef RVFI_SERIALIZER_TRAP_FWD_EN
        return e.valid || e.trap;
`else
        return e.valid;
`endif
    endfunction

    function automatic rvfi_instr_t mk(input bit v, input bit t, input logic [31:0] pc);
        rvfi_instr_t e;
        e          = '0;
        e.valid    = v;
        e.trap     = t;
        e.pc_rdata = pc;
        e.pc_wdata = pc + 32'd4;
        e.order    = {$urandom, $urandom};
        e.insn     = $urandom;
        e.cause    = 32'($urandom_range(0, 15));
        e.rd_addr  = 5'($urandom_range(0, 31));
        e.rd_wdata = $urandom;
        return e;
    endfunction

    task automatic idle();
        rvfi_in = '0;
    endtask

    task automatic compare_outputs();
        bit          exp_v;
        rvfi_instr_t exp_d;
        exp_v = (q.size() != 0) && !m_done;
        exp_d = exp_v ? q[0] : '0;
        check("valid",     256'(vld),       256'(exp_v));
        check("head",      256'(rvfi_out),  256'(exp_d));
        check("level",     256'(level),     256'(q.size()));
        check("max_level", 256'(max_level), 256'(m_max));
        check("drop_cnt",  256'(drop_cnt),  256'(m_drop));
        check("overflow",  256'(ovf),       256'(m_ovf));
        check("done",      256'(done),      256'(m_done));
    endtask

    task automatic model_step();
        rvfi_instr_t grp[$];
        bit          popped;
        bit          take;
        longint      t;
        if (!rst_n) begin
            q.delete();
            m_drop  = '0;
            m_ovf   = 0;
            m_max   = 0;
            m_drain = 0;
            m_done  = 0;
            return;
        end
        for (int i = 0; i < NP; i++) if (qualifies(rvfi_in[i])) grp.push_back(rvfi_in[i]);
        popped = (q.size() != 0) && !m_done && rdy;
        take   = 0;
        if (!m_drain && !m_done && grp.size() != 0) begin
            if (q.size() + grp.size() <= DEPTH) begin
                take = 1;
            end else begin
                t      = longint'(m_drop) + longint'(grp.size());
                m_drop = (t > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : t[31:0];
                m_ovf  = 1;
            end
        end
        if (popped) void'(q.pop_front());
        if (take) foreach (grp[k]) q.push_back(grp[k]);
        if (q.size() > m_max) m_max = q.size();
        if (m_done) begin
        end else if (m_drain) begin
            if (q.size() == 0) m_done = 1;
        end else if (eot != 32'd0) begin
            m_drain = 1;
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        compare_outputs();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic random_inputs(input int rdy_pct);
        for (int i = 0; i < NP; i++)
            rvfi_in[i] = mk(1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0), $urandom);
        rdy = ($urandom_range(0, 99) < rdy_pct);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        rdy   = 1'b0;
        eot   = 32'd0;
        idle();
        m_drop = '0; m_ovf = 0; m_max = 0; m_drain = 0; m_done = 0;
        @(posedge clk); #1;
        cycle();
        cycle();
        rst_n = 1'b1;

        // Single entry through an empty FIFO
        rvfi_in[0] = mk(1, 0, 32'h8000_0000);
        rdy = 1'b1;
        cycle();
        idle();
        repeat (3) cycle();

        // Dual commits held back, then popped one per cycle
        rdy = 1'b0;
        repeat (3) begin
            rvfi_in[0] = mk(1, 0, 32'h100);
            rvfi_in[1] = mk(1, 0, 32'h104);
            cycle();
        end
        idle();
        cycle();
        rdy = 1'b1;
        repeat (8) cycle();

        // Trap-only entry on port 0 with cause 2
        rvfi_in[0]       = mk(0, 1, 32'h200);
        rvfi_in[0].cause = 32'd2;
        cycle();
        idle();
        repeat (3) cycle();

        // Overflow: nine pairs into a 16-deep FIFO with no consumer
        rdy = 1'b0;
        repeat (9) begin
            rvfi_in[0] = mk(1, 0, $urandom);
            rvfi_in[1] = mk(1, 0, $urandom);
            cycle();
        end
        // Full FIFO with a pop in the same cycle still rejects the push
        rdy = 1'b1;
        rvfi_in[0] = mk(1, 0, $urandom);
        cycle();
        idle();
        repeat (20) cycle();

        // Mid-run reset with seven entries queued
        rdy = 1'b0;
        repeat (3) begin
            rvfi_in[0] = mk(1, 0, $urandom);
            rvfi_in[1] = mk(1, 0, $urandom);
            cycle();
        end
        rvfi_in[0] = mk(1, 0, $urandom);
        rvfi_in[1] = '0;
        cycle();
        idle();
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        cycle();

        // Randomized traffic rounds, each ending in an end-of-test drain
        for (int round = 0; round < 3; round++) begin
            for (int c = 0; c < 600; c++) begin
                random_inputs(30 + 30 * round);
                cycle();
            end
            eot = 32'd1;
            for (int c = 0; c < 64 && !m_done; c++) begin
                random_inputs(100);
                cycle();
            end
            check("drain_done_model", 256'(done), 256'(1));
            random_inputs(100);
            repeat (4) cycle();
            eot = 32'd0;
            idle();
            rst_n = 1'b0;
            cycle();
            rst_n = 1'b1;
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
